// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/cache types and default cache geometry
package cpu_types_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } icache_sa_state_t;

    localparam int ICACHE_SETS  = 8;
    localparam int ICACHE_WAYS  = 2;
    localparam int ICACHE_WORDS = 2;

endpackage

// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - per-CPU instruction port of the memory/coherence controller
interface cache_control_if #(
    parameter int CPUS = 1
);
    logic [CPUS-1:0] iREN;
    logic [CPUS-1:0] iwait;
    logic [31:0]     iaddr [CPUS];
    logic [31:0]     iload [CPUS];

    modport icache (
        output iREN, iaddr,
        input  iwait, iload
    );
endinterface

// File: rtl/datapath_cache_if.sv
// rtl/datapath_cache_if.sv - fetch stage to L1 I-cache request/response signals
interface datapath_cache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    modport icache (
        input  imemREN, imemaddr,
        output ihit, imemload
    );
endinterface

// File: rtl/icache_way.sv
// rtl/icache_way.sv - one cache way: valid/tag/data arrays, combinational lookup, word write
module icache_way #(
    parameter int SETS  = 8,
    parameter int WORDS = 2,
    parameter int IDXB  = 3,
    parameter int OFFW  = 1,
    parameter int TAGB  = 26
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            flush,
    input  logic [IDXB-1:0] rd_idx,
    input  logic [TAGB-1:0] rd_tag,
    input  logic [OFFW-1:0] rd_off,
    output logic            rd_hit,
    output logic            rd_valid,
    output logic [31:0]     rd_word,
    input  logic            wr_en,
    input  logic [IDXB-1:0] wr_idx,
    input  logic [OFFW-1:0] wr_off,
    input  logic [31:0]     wr_data,
    input  logic            fill_en,
    input  logic [TAGB-1:0] wr_tag
);

    logic [SETS-1:0] valid_q, valid_d;
    logic [TAGB-1:0] tag_q  [SETS];
    logic [TAGB-1:0] tag_d  [SETS];
    logic [31:0]     data_q [SETS][WORDS];
    logic [31:0]     data_d [SETS][WORDS];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d[wr_idx][wr_off] = wr_data;
        end
        if (fill_en) begin
            tag_d[wr_idx]   = wr_tag;
            valid_d[wr_idx] = 1'b1;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are qualified by valid, so they need no reset.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_hit   = rd_valid && (tag_q[rd_idx] == rd_tag);
    assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative L1 instruction cache with LRU and burst refill
module icache_sa
    import cpu_types_pkg::*;
#(
    parameter int CPUID = 0,
    parameter int SETS  = ICACHE_SETS,
    parameter int WAYS  = ICACHE_WAYS,
    parameter int WORDS = ICACHE_WORDS
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    iflush,
    datapath_cache_if.icache        dcif,
    cache_control_if.icache         ccif
);

    localparam int OFFB = $clog2(WORDS);
    localparam int OFFW = (OFFB == 0) ? 1 : OFFB;
    localparam int IDXB = $clog2(SETS);
    localparam int TAGB = 30 - OFFB - IDXB;

    typedef struct packed {
        logic [TAGB-1:0] tag;
        logic [IDXB-1:0] idx;
        logic [OFFW-1:0] off;
    } icache_addr_t;

    function automatic icache_addr_t split_addr(input logic [31:0] a);
        icache_addr_t r;
        r.tag = TAGB'(a >> (2 + OFFB + IDXB));
        r.idx = IDXB'(a >> (2 + OFFB));
        r.off = OFFW'((a >> 2) & 32'(WORDS - 1));
        return r;
    endfunction

    icache_sa_state_t state_q, state_d;
    logic [OFFW-1:0]  cnt_q, cnt_d;
    logic [TAGB-1:0]  rtag_q, rtag_d;
    logic [IDXB-1:0]  ridx_q, ridx_d;
    logic             victim_q, victim_d;
    logic [SETS-1:0]  lru_q, lru_d;

    icache_addr_t     req;
    logic [WAYS-1:0]  hit_w, valid_w;
    logic [31:0]      word_w [WAYS];
    logic             any_hit, hit_way, victim;
    logic             wr_en, fill_en;
    logic             ihit, iren;
    logic [31:0]      imemload, iaddr, fill_addr;

    assign req     = split_addr(dcif.imemaddr);
    assign any_hit = |hit_w;
    assign hit_way = (WAYS == 2) ? hit_w[WAYS-1] : 1'b0;

    // Prefer an empty way so a fresh line never evicts live data.
    always_comb begin
        victim = 1'b0;
        if (valid_w[0]) begin
            if ((WAYS == 2) && !valid_w[WAYS-1]) begin
                victim = 1'b1;
            end else if (WAYS == 2) begin
                victim = lru_q[req.idx];
            end
        end
    end

    assign fill_addr = (32'(rtag_q) << (2 + OFFB + IDXB))
                     | (32'(ridx_q) << (2 + OFFB))
                     | (32'(cnt_q) << 2);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rtag_d   = rtag_q;
        ridx_d   = ridx_q;
        victim_d = victim_q;
        lru_d    = lru_q;
        ihit     = 1'b0;
        imemload = 32'h0;
        iren     = 1'b0;
        iaddr    = dcif.imemaddr;
        wr_en    = 1'b0;
        fill_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dcif.imemREN) begin
                    if (any_hit) begin
                        ihit              = 1'b1;
                        imemload          = word_w[hit_way];
                        lru_d[req.idx]    = ~hit_way;
                    end else begin
                        rtag_d   = req.tag;
                        ridx_d   = req.idx;
                        victim_d = victim;
                        cnt_d    = '0;
                        state_d  = REFILL;
                    end
                end
            end
            REFILL: begin
                iren  = 1'b1;
                iaddr = fill_addr;
                if (!ccif.iwait[CPUID]) begin
                    wr_en = 1'b1;
                    cnt_d = OFFW'(cnt_q + 1'b1);
                    if (cnt_q == OFFW'(WORDS - 1)) begin
                        fill_en       = 1'b1;
                        cnt_d         = '0;
                        lru_d[ridx_q] = ~victim_q;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over everything, including a completing refill.
        if (iflush) begin
            lru_d   = '0;
            state_d = IDLE;
            cnt_d   = '0;
            wr_en   = 1'b0;
            fill_en = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rtag_q   <= '0;
            ridx_q   <= '0;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rtag_q   <= rtag_d;
            ridx_q   <= ridx_d;
            victim_q <= victim_d;
            lru_q    <= lru_d;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS  (SETS),
            .WORDS (WORDS),
            .IDXB  (IDXB),
            .OFFW  (OFFW),
            .TAGB  (TAGB)
        ) u_way (
            .CLK      (CLK),
            .nRST     (nRST),
            .flush    (iflush),
            .rd_idx   (req.idx),
            .rd_tag   (req.tag),
            .rd_off   (req.off),
            .rd_hit   (hit_w[w]),
            .rd_valid (valid_w[w]),
            .rd_word  (word_w[w]),
            .wr_en    (wr_en && (victim_q == 1'(w))),
            .wr_idx   (ridx_q),
            .wr_off   (cnt_q),
            .wr_data  (ccif.iload[CPUID]),
            .fill_en  (fill_en && (victim_q == 1'(w))),
            .wr_tag   (rtag_q)
        );
    end

    assign dcif.ihit         = ihit;
    assign dcif.imemload     = imemload;
    assign ccif.iREN[CPUID]  = iren;
    assign ccif.iaddr[CPUID] = iaddr;

endmodule

// File: tb/tb_icache_sa.sv
// tb/tb_icache_sa.sv - self-checking bench for icache_sa against a tag-queue LRU model
module tb_icache_sa;

    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int WORDS = 2;
    localparam int OFFB  = $clog2(WORDS);
    localparam int IDXB  = $clog2(SETS);

    logic CLK = 1'b0;
    logic nRST;
    logic iflush;

    datapath_cache_if           dcif ();
    cache_control_if #(.CPUS(1)) ccif ();

    icache_sa #(
        .CPUID (0),
        .SETS  (SETS),
        .WAYS  (WAYS),
        .WORDS (WORDS)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .iflush (iflush),
        .dcif   (dcif),
        .ccif   (ccif)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign ccif.iload[0] = mem_word(ccif.iaddr[0]);

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: each set is a list of resident tags, most recently used first.
    int unsigned mq [SETS][$];

    function automatic int unsigned m_tag(input logic [31:0] a);
        return a >> (2 + OFFB + IDXB);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> (2 + OFFB)) % SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s = m_idx(a);
        for (int i = 0; i < mq[s].size(); i++) begin
            if (mq[s][i] == m_tag(a)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_touch(input logic [31:0] a);
        int s = m_idx(a);
        int pos = -1;
        for (int i = 0; i < mq[s].size(); i++) begin
            if (mq[s][i] == m_tag(a)) pos = i;
        end
        if (pos >= 0) mq[s].delete(pos);
        mq[s].push_front(m_tag(a));
        if (mq[s].size() > WAYS) void'(mq[s].pop_back());
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) mq[s].delete();
    endtask

    task automatic flush_pulse();
        iflush = 1'b1;
        @(negedge CLK);
        iflush = 1'b0;
        model_flush();
    endtask

    // Full fetch starting just after a negedge with the cache idle.
    // wmode: 0 no wait, 1 random wait, 3 three wait cycles per word. exp_hit 2 = don't care.
    task automatic fetch(input logic [31:0] addr, input int wmode, input int exp_hit);
        bit          mh     = model_hit(addr);
        int          cycles = 0;
        int          waits  = 0;
        int          done_w = 0;
        int          wc     = 0;
        bit          got    = 1'b0;
        logic [31:0] base   = addr & ~32'(WORDS * 4 - 1);
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = addr;
        while (!got && cycles < 200) begin
            case (wmode)
                1:       ccif.iwait = ($urandom_range(0, 3) == 0);
                3:       ccif.iwait = (wc < 3);
                default: ccif.iwait = 1'b0;
            endcase
            #1;
            if (dcif.ihit) begin
                got = 1'b1;
                chk("hit_data", dcif.imemload, mem_word(addr));
            end else begin
                chk("miss_load_zero", dcif.imemload, 32'h0);
                if (ccif.iREN[0]) begin
                    chk("refill_iaddr", ccif.iaddr[0], base + 32'(4 * done_w));
                    if (ccif.iwait[0]) begin
                        waits++;
                        wc++;
                    end else begin
                        done_w++;
                        wc = 0;
                    end
                end else begin
                    chk("idle_iaddr", ccif.iaddr[0], addr);
                end
            end
            @(negedge CLK);
            if (!got) cycles++;
        end
        chk("hit_seen", 32'(got), 32'd1);
        chk("latency", 32'(cycles), mh ? 32'd0 : 32'(1 + WORDS + waits));
        if (exp_hit != 2) chk("hit_expect", 32'(cycles == 0), 32'(exp_hit));
        if (wmode == 3 && !mh) chk("wait_total", 32'(waits), 32'(3 * WORDS));
        dcif.imemREN = 1'b0;
        ccif.iwait   = 1'b0;
        model_touch(addr);
    endtask

    initial begin
        int n;
        nRST          = 1'b0;
        iflush        = 1'b0;
        dcif.imemREN  = 1'b0;
        dcif.imemaddr = 32'h0;
        ccif.iwait    = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ihit", 32'(dcif.ihit), 32'd0);
        chk("rst_iren", 32'(ccif.iREN[0]), 32'd0);
        chk("rst_load", dcif.imemload, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // Cold miss then spatial hit in the same block.
        fetch(32'h40, 0, 0);
        fetch(32'h44, 0, 1);

        // LRU replacement within set 0.
        fetch(32'h80, 0, 0);
        fetch(32'h40, 0, 1);
        fetch(32'hC0, 0, 0);
        fetch(32'h40, 0, 1);
        fetch(32'h80, 0, 0);

        // Slow memory: three wait cycles per word.
        fetch(32'h300, 3, 0);

        // Flush in idle invalidates everything.
        flush_pulse();
        fetch(32'h40, 0, 0);
        fetch(32'h80, 0, 0);

        // Address change during refill is ignored until the refill finishes.
        flush_pulse();
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = 32'h40;
        #1;
        chk("chg_first_miss", 32'(dcif.ihit), 32'd0);
        @(negedge CLK);
        dcif.imemaddr = 32'h100;
        #1;
        chk("chg_latched_iaddr", ccif.iaddr[0], 32'h40);
        n = 0;
        while (!dcif.ihit && n < 50) begin
            @(negedge CLK);
            n++;
            #1;
        end
        chk("chg_latency", 32'(n), 32'd5);
        chk("chg_data", dcif.imemload, mem_word(32'h100));
        @(negedge CLK);
        dcif.imemREN = 1'b0;
        model_touch(32'h40);
        model_touch(32'h100);
        fetch(32'h40, 0, 1);
        fetch(32'h100, 0, 1);

        // Flush on the final refill word aborts the fill.
        flush_pulse();
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = 32'h40;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("flush_last_iren", 32'(ccif.iREN[0]), 32'd1);
        chk("flush_last_iaddr", ccif.iaddr[0], 32'h44);
        iflush = 1'b1;
        @(negedge CLK);
        iflush       = 1'b0;
        dcif.imemREN = 1'b0;
        model_flush();
        fetch(32'h40, 0, 0);

        // Randomized traffic over a small address pool with occasional flushes.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) flush_pulse();
            fetch(32'($urandom_range(0, 255)) * 4, 1, 2);
        end

        // Reset in the middle of a refill.
        flush_pulse();
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = 32'h48;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("pre_rst_iren", 32'(ccif.iREN[0]), 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_iren", 32'(ccif.iREN[0]), 32'd0);
        chk("mid_rst_ihit", 32'(dcif.ihit), 32'd0);
        @(negedge CLK);
        nRST         = 1'b1;
        dcif.imemREN = 1'b0;
        model_flush();
        @(negedge CLK);
        for (int i = 0; i < SETS; i++) begin
            fetch(32'h200 + 32'(i * 8), 0, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache: the next-generation L1 I-cache between the fetch stage and the memory/coherence controller. It generalises the current direct-mapped, one-word-per-frame cache to WAYS-way sets with multi-word blocks, LRU replacement, and a flush input. Multi-word refill runs as a sequential burst on the controller's instruction port.

## Interface
Parameters:
- CPUID, 0, index into the per-CPU arrays of cache_control_if
- SETS, 8, number of sets; power of two, 2..64
- WAYS, 2, associativity; 1 or 2 only
- WORDS, 2, words per block; power of two, 1..8

Ports (reset nRST, asynchronous, active-low; clock CLK):
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- iflush  in  1  invalidate the entire cache
- dcif.imemREN  in  1  fetch request
- dcif.imemaddr  in  32  byte address, word aligned
- dcif.ihit  out  1  imemload is valid this cycle
- dcif.imemload  out  32  instruction word
- ccif.iREN[CPUID]  out  1  memory read request
- ccif.iaddr[CPUID]  out  32  memory word address
- ccif.iwait[CPUID]  in  1  memory not ready
- ccif.iload[CPUID]  in  32  memory read data

## Operation
- Address split, LSB first:
  - 2-bit byte offset, ignored
  - log2(WORDS) block offset
  - log2(SETS) index
  - tag is the remaining upper bits
- Per way per set: valid bit, tag, WORDS data words. Per set: one LRU bit (WAYS=2; it names the least-recently-used way).
- FSM states: IDLE, REFILL.
- IDLE:
  - If imemREN is high and any way in the set has a valid, matching tag: ihit=1, imemload = that word, and LRU points to the other way.
  - On a miss with imemREN high: latch {tag, idx} and pick the victim way, then go to REFILL with word counter cnt=0.
  - Victim way: the lowest-numbered invalid way, otherwise the LRU way.
- REFILL:
  - iREN=1; iaddr = {latched tag, latched idx, cnt, 2'b00}.
  - Each cycle iwait=0: write iload into victim word cnt, then cnt++.
  - On the last word (cnt==WORDS-1, iwait=0): write the tag, set valid, make the victim MRU, go to IDLE.
  - ihit stays 0 throughout REFILL.
- A change of imemaddr during REFILL is ignored. The refill completes using the latched address, and the new address is looked up in IDLE.
- iflush:
  - Clears all valid bits and LRU bits on the next edge, in any state.
  - In REFILL it aborts the refill: no tag or valid is written, state goes to IDLE, cnt=0.
  - iflush has priority over a same-cycle final refill word.
- imemREN low in IDLE: no lookup side effects (LRU unchanged), ihit=0.
- Outputs when not hitting: imemload=32'h0. In IDLE, iREN=0 and iaddr=imemaddr.

## Timing
- Reset values:
  - state IDLE, cnt 0, all valid 0, all LRU 0
  - ihit 0, iREN 0, imemload 0
- Hit: combinational; ihit is asserted in the same cycle as the address.
- Miss: first cycle is IDLE with ihit=0. Then REFILL lasts WORDS cycles plus the total iwait cycles. ihit is asserted on the first IDLE cycle after that.
- Miss penalty with zero-wait memory: WORDS+1 cycles.
- Reset mid-REFILL: all state is cleared asynchronously and iREN drops immediately.

## Structure
- cpu_types_pkg gains:
  - icache_sa_state_t enum {IDLE, REFILL}
  - default constants ICACHE_SETS, ICACHE_WAYS, ICACHE_WORDS
- Field widths and the local address struct are derived from the parameters inside the module.
- Sub-module icache_way, instantiated WAYS times. Each holds the tag/valid/data arrays for one way and provides:
  - a combinational lookup port: hit and word
  - a write port: word write, tag/valid set
  - a flush input

## Test plan
With SETS=8, WAYS=2, WORDS=2, address 0x40 maps to tag 1, idx 0.
- Reset, then read 0x40 with iwait=0: ihit=0 for 3 cycles, iaddr steps 0x40 then 0x44, then ihit=1 with the word loaded for 0x40. A following read of 0x44 hits with 0 wait.
- Fill 0x40 and 0x80, re-touch 0x40, then miss on 0xC0: the refill replaces the 0x80 way. Then 0x40 hits and 0x80 misses.
- Refill with iwait=1 for 3 cycles per word: REFILL lasts 8 cycles and iaddr holds each value while iwait=1.
- Change imemaddr to 0x100 mid-refill of 0x40: the 0x40 line is filled, then 0x100 misses and refills.
- Assert iflush on the last refill word of 0x40: the line stays invalid and a re-read of 0x40 misses. Assert iflush in IDLE: all previous hits miss.
- Assert nRST low mid-REFILL: iREN=0 and ihit=0 immediately, and every address misses after release.
